// File: rtl/pipe_add_ncarry.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// carry registered between chunks, operands skewed in and sums deskewed out.
module pipe_add_ncarry #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o,
    output logic             ovf_o
);
    localparam int C = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipe_add_ncarry: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  sum_out;
    logic              msb_a;
    logic              msb_b;
    logic              msb_s;
    logic              msb_cout;
    logic              ovf_next;
    logic [STAGES-1:0] valid_reg;
    logic              ovf_reg;

    // Subtraction is a + ~b + 1; the user carry-in is dropped in that mode.
    assign b_eff   = sub_i ? ~b_i : b_i;
    assign cin_eff = sub_i ? 1'b1 : ci_i;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_chunk
        logic [C-1:0] op_a;
        logic [C-1:0] op_b;
        logic         c_in;
        logic [C:0]   chunk_sum;
        logic         carry_reg;
        logic [C-1:0] sum_dly_reg [STAGES-gi];

        if (gi == 0) begin : g_head
            assign op_a = a_i[C-1:0];
            assign op_b = b_eff[C-1:0];
            assign c_in = cin_eff;
        end else begin : g_skew
            // Chunk gi waits gi cycles so it lines up with the carry from chunk gi-1.
            logic [C-1:0] a_skew_reg [gi];
            logic [C-1:0] b_skew_reg [gi];

            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    for (int i = 0; i < gi; i++) begin
                        a_skew_reg[i] <= '0;
                        b_skew_reg[i] <= '0;
                    end
                end else if (en_i) begin
                    a_skew_reg[0] <= a_i[gi*C +: C];
                    b_skew_reg[0] <= b_eff[gi*C +: C];
                    for (int i = 1; i < gi; i++) begin
                        a_skew_reg[i] <= a_skew_reg[i-1];
                        b_skew_reg[i] <= b_skew_reg[i-1];
                    end
                end
            end

            assign op_a = a_skew_reg[gi-1];
            assign op_b = b_skew_reg[gi-1];
            assign c_in = carry_q[gi-1];
        end

        assign chunk_sum = {1'b0, op_a} + {1'b0, op_b} + {{C{1'b0}}, c_in};

        // Element 0 is the stage register; the rest hold the chunk until the MSB chunk is done.
        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                carry_reg <= 1'b0;
                for (int i = 0; i < STAGES - gi; i++) begin
                    sum_dly_reg[i] <= '0;
                end
            end else if (en_i) begin
                carry_reg      <= chunk_sum[C];
                sum_dly_reg[0] <= chunk_sum[C-1:0];
                for (int i = 1; i < STAGES - gi; i++) begin
                    sum_dly_reg[i] <= sum_dly_reg[i-1];
                end
            end
        end

        assign carry_q[gi]        = carry_reg;
        assign sum_out[gi*C +: C] = sum_dly_reg[STAGES-1-gi];

        if (gi == STAGES - 1) begin : g_msb
            assign msb_a    = op_a[C-1];
            assign msb_b    = op_b[C-1];
            assign msb_s    = chunk_sum[C-1];
            assign msb_cout = chunk_sum[C];
        end
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    assign ovf_next = msb_a ^ msb_b ^ msb_s ^ msb_cout;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            valid_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (en_i) begin
            valid_reg[0] <= valid_i;
            for (int i = 1; i < STAGES; i++) begin
                valid_reg[i] <= valid_reg[i-1];
            end
            ovf_reg <= ovf_next;
        end
    end

    assign valid_o = valid_reg[STAGES-1];
    assign s_o     = sum_out;
    assign co_o    = carry_q[STAGES-1];
    assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_pipe_add_ncarry.sv
// Scoreboard bench for pipe_add_ncarry: three configurations driven in lockstep.
module tb_pipe_add_ncarry;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, en, valid, sub, ci;
    logic [15:0] a, b;

    logic        v16, co16, ovf16;
    logic [15:0] s16;
    logic        v8, co8, ovf8;
    logic [7:0]  s8;
    logic        v12, co12, ovf12;
    logic [11:0] s12;

    pipe_add_ncarry #(.WIDTH(16), .STAGES(4)) dut16 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .valid_i(valid), .sub_i(sub),
        .a_i(a), .b_i(b), .ci_i(ci),
        .valid_o(v16), .s_o(s16), .co_o(co16), .ovf_o(ovf16));

    pipe_add_ncarry #(.WIDTH(8), .STAGES(1)) dut8 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .valid_i(valid), .sub_i(sub),
        .a_i(a[7:0]), .b_i(b[7:0]), .ci_i(ci),
        .valid_o(v8), .s_o(s8), .co_o(co8), .ovf_o(ovf8));

    pipe_add_ncarry #(.WIDTH(12), .STAGES(3)) dut12 (
        .clk_i(clk), .rstn_i(rstn), .en_i(en), .valid_i(valid), .sub_i(sub),
        .a_i(a[11:0]), .b_i(b[11:0]), .ci_i(ci),
        .valid_o(v12), .s_o(s12), .co_o(co12), .ovf_o(ovf12));

    int compared   = 0;
    int mismatched = 0;

    // Entries are {ovf, co, sum[15:0]}.
    logic [17:0] q16[$];
    logic [17:0] q8[$];
    logic [17:0] q12[$];

    function automatic logic [17:0] model(int w, logic [15:0] x, logic [15:0] y,
                                          logic s, logic c);
        logic [16:0] mask, xa, yb, full, low;
        logic        cin, co, cmsb;
        mask = (17'd1 << w) - 17'd1;
        xa   = {1'b0, x} & mask;
        yb   = s ? (~{1'b0, y}) & mask : {1'b0, y} & mask;
        cin  = s ? 1'b1 : c;
        full = xa + yb + {16'd0, cin};
        co   = full[w];
        low  = (xa & (mask >> 1)) + (yb & (mask >> 1)) + {16'd0, cin};
        cmsb = low[w-1];
        return {cmsb ^ co, co, full[15:0] & mask[15:0]};
    endfunction

    // Applies one cycle of stimulus at the falling edge; accepted ops go to the scoreboard.
    task automatic drive(input logic e, input logic v, input logic sb, input logic c,
                         input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        en = e; valid = v; sub = sb; ci = c; a = x; b = y;
        if (e && v && rstn) begin
            q16.push_back(model(16, x, y, sb, c));
            q8.push_back(model(8, x, y, sb, c));
            q12.push_back(model(12, x, y, sb, c));
        end
    endtask

    // Scoreboard monitor: after every enabled, non-reset edge, pop and compare each valid result.
    logic        take;
    logic [17:0] exp_m;
    always @(posedge clk) begin
        take = rstn && en;
        #1;
        if (take && v16) begin
            compared++;
            if (q16.size() == 0) begin
                mismatched++;
                $display("FAIL sb16_unexpected: got s=%h co=%b ovf=%b, required no valid", s16, co16, ovf16);
            end else begin
                exp_m = q16.pop_front();
                if ({ovf16, co16, s16} !== exp_m) begin
                    mismatched++;
                    $display("FAIL sb16: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                             s16, co16, ovf16, exp_m[15:0], exp_m[16], exp_m[17]);
                end
            end
        end
        if (take && v8) begin
            compared++;
            if (q8.size() == 0) begin
                mismatched++;
                $display("FAIL sb8_unexpected: got s=%h, required no valid", s8);
            end else begin
                exp_m = q8.pop_front();
                if ({ovf8, co8, s8} !== {exp_m[17:16], exp_m[7:0]}) begin
                    mismatched++;
                    $display("FAIL sb8: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                             s8, co8, ovf8, exp_m[7:0], exp_m[16], exp_m[17]);
                end
            end
        end
        if (take && v12) begin
            compared++;
            if (q12.size() == 0) begin
                mismatched++;
                $display("FAIL sb12_unexpected: got s=%h, required no valid", s12);
            end else begin
                exp_m = q12.pop_front();
                if ({ovf12, co12, s12} !== {exp_m[17:16], exp_m[11:0]}) begin
                    mismatched++;
                    $display("FAIL sb12: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                             s12, co12, ovf12, exp_m[11:0], exp_m[16], exp_m[17]);
                end
            end
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        // en=0 during reset: reset must still clear everything.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, 16'hA5A5, 16'h5A5A);
        compared++;
        if ({v16, s16, co16, ovf16, v8, s8, co8, ovf8, v12, s12, co12, ovf12} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got v16=%b s16=%h v8=%b s8=%h v12=%b s12=%h, required all 0",
                     v16, s16, v8, s8, v12, s12);
        end
        $display("reset: outputs v16=%b s16=%h", v16, s16);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_latency();
        int n;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0001);
        n = 0;
        while (!v16 && n < 10) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            n++;
        end
        compared++;
        if (n !== 4 || s16 !== 16'h0100 || co16 !== 1'b0 || ovf16 !== 1'b0) begin
            mismatched++;
            $display("FAIL latency_carry: got lat=%0d s=%h co=%b ovf=%b, required lat=4 s=0100 co=0 ovf=0",
                     n, s16, co16, ovf16);
        end
        $display("latency: 00FF+0001 -> s=%h after %0d cycles", s16, n);
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001);
        n = 0;
        while (!v16 && n < 10) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            n++;
        end
        compared++;
        if (v16 !== 1'b1 || s16 !== 16'h0000 || co16 !== 1'b1 || ovf16 !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_first: got v=%b s=%h co=%b ovf=%b, required v=1 s=0000 co=1 ovf=0",
                     v16, s16, co16, ovf16);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        compared++;
        if (v16 !== 1'b1 || s16 !== 16'h8000 || co16 !== 1'b0 || ovf16 !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_second: got v=%b s=%h co=%b ovf=%b, required v=1 s=8000 co=0 ovf=1",
                     v16, s16, co16, ovf16);
        end
        $display("back_to_back: second result s=%h co=%b ovf=%b", s16, co16, ovf16);
    endtask

    task automatic test_sub();
        int n;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h8000, 16'h0001);
        n = 0;
        while (!v16 && n < 10) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            n++;
        end
        compared++;
        if (v16 !== 1'b1 || s16 !== 16'hFFFE || co16 !== 1'b0 || ovf16 !== 1'b0) begin
            mismatched++;
            $display("FAIL sub_borrow: got v=%b s=%h co=%b ovf=%b, required v=1 s=FFFE co=0 ovf=0",
                     v16, s16, co16, ovf16);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        compared++;
        if (v16 !== 1'b1 || s16 !== 16'h7FFF || co16 !== 1'b1 || ovf16 !== 1'b1) begin
            mismatched++;
            $display("FAIL sub_ovf: got v=%b s=%h co=%b ovf=%b, required v=1 s=7FFF co=1 ovf=1",
                     v16, s16, co16, ovf16);
        end
        $display("sub: 8000-0001 -> s=%h co=%b ovf=%b", s16, co16, ovf16);
    endtask

    task automatic test_stall();
        logic [18:0] snap;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h1111);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0001);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h8001, 16'h8001);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0F0F, 16'hF0F1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
        snap = {v16, co16, ovf16, s16};
        compared++;
        if (v16 !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_first_out: got v=%b, required v=1", v16);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b0, 1'b1, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF);
            else       drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            compared++;
            if ({v16, co16, ovf16, s16} !== snap) begin
                mismatched++;
                $display("FAIL stall_hold[%0d]: got %h, required %h", i, {v16, co16, ovf16, s16}, snap);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            compared++;
            if (v16 !== (i < 3)) begin
                mismatched++;
                $display("FAIL stall_resume[%0d]: got v=%b, required v=%b", i, v16, i < 3);
            end
        end
        $display("stall: 3-cycle stall held s=%h, remaining 3 results drained", snap[15:0]);
    endtask

    task automatic test_reset_flush();
        int n;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h1111, 16'h2222);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h3333, 16'h4444);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rstn = 1'b0;
        valid = 1'b0;
        q16.delete(); q8.delete(); q12.delete();
        @(negedge clk);
        rstn = 1'b1;
        compared++;
        if ({v16, s16, co16, ovf16, v8, v12} !== '0) begin
            mismatched++;
            $display("FAIL flush_state: got v16=%b s16=%h co=%b ovf=%b v8=%b v12=%b, required all 0",
                     v16, s16, co16, ovf16, v8, v12);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            compared++;
            if (v16 !== 1'b0) begin
                mismatched++;
                $display("FAIL flush_stale[%0d]: got v=%b s=%h, required v=0", i, v16, s16);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0FFF, 16'h0000);
        n = 0;
        while (!v16 && n < 10) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            n++;
        end
        compared++;
        if (n !== 4 || s16 !== 16'h1000 || co16 !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_new_op: got lat=%0d s=%h co=%b, required lat=4 s=1000 co=0", n, s16, co16);
        end
        $display("reset_flush: post-reset op s=%h after %0d cycles", s16, n);
    endtask

    task automatic test_random();
        int ops = 0;
        while (ops < 10000) begin
            logic e, v;
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 4) != 0);
            drive(e, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
            if (e && v) ops++;
        end
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        compared++;
        if (q16.size() != 0 || q8.size() != 0 || q12.size() != 0) begin
            mismatched++;
            $display("FAIL random_drain: got pending %0d/%0d/%0d, required 0/0/0",
                     q16.size(), q8.size(), q12.size());
        end
        $display("random: %0d operations issued to each configuration", ops);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; en = 1'b0; valid = 1'b0; sub = 1'b0; ci = 1'b0;
        a = '0; b = '0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_sub();
        test_stall();
        test_reset_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
